ip_tx_arbiter: RTL
==================

// Module: ip_tx_arbiter
// PURPOSE
// Shares the single IPv4/UDP TX packetiser between NUM_REQ accelerator-side requesters (e.g. LB responses, inference results).
// Round-robin arbitration; latches the winner's recipient IP, MAC and message; drives the packetiser start handshake.
// Holds the grant until the packet's final MAC beat completes. Sits between the accelerator core and the packetiser/MAC path.
// PARAMETERS
// NUM_REQ           2     number of requesters (>=2)
// IP_ADDR_WIDTH     32    recipient IP width
// MAC_ADDR_WIDTH    48    recipient MAC width
// ACCEL_DATA_WIDTH  10    message width
// WDOG_CYCLES       1024  watchdog limit in cycles (used only with IP_TX_ARB_WATCHDOG_EN)
// PORTS
// aclk                      in   1                      clock, rising edge
// areset                    in   1                      reset, asynchronous, active-high
// REQ_VALID                 in   NUM_REQ                per-requester send request
// REQ_READY                 out  NUM_REQ                one-hot accept pulse; fields latched on this edge
// REQ_IP_ADDRESS            in   NUM_REQ*IP_ADDR_WIDTH  packed; slice i belongs to requester i
// REQ_MAC_ADDRESS           in   NUM_REQ*MAC_ADDR_WIDTH packed recipient MACs
// REQ_MESSAGE               in   NUM_REQ*ACCEL_DATA_WIDTH packed messages
// TX_RECIPIENT_IP_ADDRESS   out  IP_ADDR_WIDTH          latched IP to packetiser
// TX_RECIPIENT_MAC_ADDRESS  out  MAC_ADDR_WIDTH         latched MAC to packetiser
// TX_RECIPIENT_MESSAGE      out  ACCEL_DATA_WIDTH       latched message to packetiser
// TX_START_IP_TXN           out  1                      start request to packetiser
// TX_READY_FOR_SEND         in   1                      packetiser accepts start when high with TX_START_IP_TXN
// MAC_DATA_VALID            in   1                      monitored MAC stream valid
// MAC_DATA_READY            in   1                      monitored MAC stream ready
// MAC_DATA_LAST             in   1                      monitored MAC stream last beat
// GRANT_ID                  out  $clog2(NUM_REQ)        index of current/last granted requester
// BUSY                      out  1                      high in ISSUE and WAIT_DONE
// ABORT                     out  1                      one-cycle watchdog abort pulse
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; rr pointer last=NUM_REQ-1 so requester 0 wins first.
// - IDLE: if any REQ_VALID, winner = first valid scanning last+1, last+2, ... (mod NUM_REQ); REQ_READY[winner]=1 combinationally
//   same cycle; TX_* fields and GRANT_ID registered on that edge; next state ISSUE. REQ_READY=0 in all other states.
// - ISSUE: TX_START_IP_TXN=1; if TX_READY_FOR_SEND=1 in the same cycle -> WAIT_DONE; else hold.
// - WAIT_DONE: exit to IDLE on beat MAC_DATA_VALID & MAC_DATA_READY & MAC_DATA_LAST; last<=GRANT_ID on that edge.
// - Latency: REQ_VALID in IDLE -> TX_START_IP_TXN high next cycle. Completion -> re-arbitration next cycle (one idle bubble).
// - TX_* fields stable from latch until exit from WAIT_DONE; unchanged (not cleared) in IDLE.
// - LAST beat without VALID&READY ignored; LAST seen in IDLE/ISSUE ignored.
// - Requester dropping REQ_VALID before accept loses its turn silently; no ready/valid protocol check.
// - areset mid-packet: immediate IDLE, outputs 0, pointer reinitialised; no start re-issued.
// CONFIGURATION
// - IP_TX_ARB_WATCHDOG_EN defined: 16-bit cycle counter cleared on IDLE->ISSUE, increments in ISSUE and WAIT_DONE;
//   on reaching WDOG_CYCLES-1 without completion: ABORT=1 for one cycle, state->IDLE, last<=GRANT_ID.
// - Undefined: counter absent, ABORT tied 0, arbiter waits indefinitely for completion.
// TESTING
// - Req0 only, IP=0x0A000002, MAC=0x112233445566, MSG=0x155 -> REQ_READY=2'b01 one cycle; next cycle TX_START=1 with those values; BUSY=0 after LAST beat.
// - REQ_VALID=2'b11 held, each packet completed -> GRANT_ID sequence 0,1,0,1; REQ_READY never 2'b11.
// - TX_READY_FOR_SEND low 5 cycles in ISSUE -> TX_START_IP_TXN held 5+1 cycles, TX_* fields unchanged, REQ_READY=0.
// - MAC_DATA_LAST=1 with MAC_DATA_READY=0 -> stays WAIT_DONE; then READY=1 -> IDLE next cycle.
// - areset pulse in WAIT_DONE while req1 granted -> outputs 0; after release with REQ_VALID=2'b11 -> requester 0 granted.
// - Macro on, WDOG_CYCLES=16, no LAST -> ABORT pulse 16 cycles after ISSUE entry, then next requester granted; macro off -> BUSY stays 1.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing the IPv4/UDP TX packetiser among NUM_REQ requesters.
// Optional watchdog abort is enabled by defining IP_TX_ARB_WATCHDOG_EN.
module ip_tx_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int ACCEL_DATA_WIDTH = 10,
  parameter int WDOG_CYCLES      = 1024
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [NUM_REQ-1:0]                   REQ_VALID,
  output logic [NUM_REQ-1:0]                   REQ_READY,
  input  logic [NUM_REQ*IP_ADDR_WIDTH-1:0]     REQ_IP_ADDRESS,
  input  logic [NUM_REQ*MAC_ADDR_WIDTH-1:0]    REQ_MAC_ADDRESS,
  input  logic [NUM_REQ*ACCEL_DATA_WIDTH-1:0]  REQ_MESSAGE,
  output logic [IP_ADDR_WIDTH-1:0]             TX_RECIPIENT_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]            TX_RECIPIENT_MAC_ADDRESS,
  output logic [ACCEL_DATA_WIDTH-1:0]          TX_RECIPIENT_MESSAGE,
  output logic                                 TX_START_IP_TXN,
  input  logic                                 TX_READY_FOR_SEND,
  input  logic                                 MAC_DATA_VALID,
  input  logic                                 MAC_DATA_READY,
  input  logic                                 MAC_DATA_LAST,
  output logic [$clog2(NUM_REQ)-1:0]           GRANT_ID,
  output logic                                 BUSY,
  output logic                                 ABORT
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]                  state_r;
  logic [1:0]                  state_nxt_s;
  logic [GW-1:0]               last_r;
  logic [GW-1:0]               winner_s;
  logic                        found_s;
  logic [NUM_REQ-1:0]          ready_s;
  logic                        done_s;
  logic                        wdog_hit_s;
  logic                        abort_s;
  logic                        abort_r;

  logic [IP_ADDR_WIDTH-1:0]    ip_a_s  [NUM_REQ];
  logic [MAC_ADDR_WIDTH-1:0]   mac_a_s [NUM_REQ];
  logic [ACCEL_DATA_WIDTH-1:0] msg_a_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ip_a_s[g]  = REQ_IP_ADDRESS[g*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
    assign mac_a_s[g] = REQ_MAC_ADDRESS[g*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
    assign msg_a_s[g] = REQ_MESSAGE[g*ACCEL_DATA_WIDTH +: ACCEL_DATA_WIDTH];
  end

  assign done_s = MAC_DATA_VALID & MAC_DATA_READY & MAC_DATA_LAST;

  // Round-robin scan starting just after the last served requester.
  always_comb begin
    int            sum_v;
    logic [GW-1:0] idx_v;
    logic          hit_v;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_v    = int'(last_r) + k;
      sum_v    = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
      idx_v    = GW'(sum_v);
      hit_v    = !found_s && REQ_VALID[idx_v];
      winner_s = hit_v ? idx_v : winner_s;
      found_s  = found_s | hit_v;
    end
  end

  // One-hot accept pulse, only while idle.
  always_comb begin
    ready_s = '0;
    if ((state_r == ST_IDLE) && found_s) begin
      ready_s[winner_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign REQ_READY = ready_s;

`ifdef IP_TX_ARB_WATCHDOG_EN
  logic [15:0] wdog_r;

  assign wdog_hit_s = (state_r != ST_IDLE) && (wdog_r == 16'(WDOG_CYCLES - 1));

  // Busy-cycle counter, restarted on every new grant.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wdog_r <= 16'd0;
    end else if ((state_r == ST_IDLE) && found_s) begin
      wdog_r <= 16'd0;
    end else if (state_r != ST_IDLE) begin
      wdog_r <= wdog_r + 16'd1;
    end else begin
      wdog_r <= wdog_r;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
`endif

  // A completing beat takes priority over a simultaneous watchdog expiry.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = found_s ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        if (wdog_hit_s) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else if (TX_READY_FOR_SEND) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          state_nxt_s = ST_IDLE;
        end else if (wdog_hit_s) begin
          state_nxt_s = ST_IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, rr pointer and latched packet fields.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r                  <= ST_IDLE;
      last_r                   <= GW'(NUM_REQ - 1);
      GRANT_ID                 <= '0;
      TX_RECIPIENT_IP_ADDRESS  <= '0;
      TX_RECIPIENT_MAC_ADDRESS <= '0;
      TX_RECIPIENT_MESSAGE     <= '0;
      abort_r                  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      abort_r <= abort_s;
      if ((state_r == ST_IDLE) && found_s) begin
        GRANT_ID                 <= winner_s;
        TX_RECIPIENT_IP_ADDRESS  <= ip_a_s[winner_s];
        TX_RECIPIENT_MAC_ADDRESS <= mac_a_s[winner_s];
        TX_RECIPIENT_MESSAGE     <= msg_a_s[winner_s];
      end
      if (((state_r == ST_WAIT) && done_s) || abort_s) begin
        last_r <= GRANT_ID;
      end
    end
  end

  assign TX_START_IP_TXN = (state_r == ST_ISSUE);
  assign BUSY            = (state_r != ST_IDLE);
  assign ABORT           = abort_r;

endmodule
